ahb_lite_master: RTL and testbench

Single-outstanding AHB-Lite initiator converting a valid/ready request/response interface (LSU, debug, DMA) into AHB single transfers toward the existing AHB slaves (GPIO, timer, UART). Issues one NONSEQ SINGLE transfer per request. Honours slave wait states and two-cycle ERROR responses. Performs byte-lane replication on writes and lane extraction with zero-extension on reads. Misaligned requests are rejected locally without any bus activity.

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_lane_align.sv | 38 +++
 rtl/ahb_lite_master.sv | 133 +++++++++++++
 tb/tb_ahb_lite_master.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite protocol constants shared by the initiators and the GPIO/timer/UART slaves.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane handling for 32-bit AHB: write replication, read extraction with
// zero-extension, and alignment checking.
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  always_comb begin
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    misaligned_o = 1'b0;
    case ({1'b0, size_i})
      HSIZE_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'b0, rdata_i[8*addr_lsb_i +: 8]};
      end
      HSIZE_HALF: begin
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {16'b0, rdata_i[16*addr_lsb_i[1] +: 16]};
        misaligned_o = addr_lsb_i[0];
      end
      HSIZE_WORD: begin
        misaligned_o = |addr_lsb_i;
      end
      default: begin
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one NONSEQ SINGLE transfer per
// valid/ready request, with wait-state and ERROR handling.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] haddr_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [1:0]        htrans_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [DWIDTH-1:0] hrdata_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [1:0]        al_size;
  logic [1:0]        al_addr_lsb;
  logic [DWIDTH-1:0] al_wdata;
  logic [DWIDTH-1:0] al_rdata;
  logic              al_misaligned;

  // One aligner serves both ends: incoming request while idle, captured request afterwards.
  assign al_size     = (state_q == ST_IDLE) ? req_size_i      : size_q;
  assign al_addr_lsb = (state_q == ST_IDLE) ? req_addr_i[1:0] : addr_q[1:0];

  ahb_lane_align u_align (
    .size_i       (al_size),
    .addr_lsb_i   (al_addr_lsb),
    .wdata_i      (req_wdata_i),
    .rdata_i      (hrdata_i),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_misaligned)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i;
          wdata_d = al_wdata;
          rdata_d = '0;
          err_d   = al_misaligned;
          state_d = al_misaligned ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (hready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        // The first ERROR cycle arrives with hready low and is deliberately not sampled.
        if (hready_i) begin
          err_d   = (hresp_i == HRESP_ERROR);
          rdata_d = (hresp_i == HRESP_ERROR || write_q) ? '0 : al_rdata;
          state_d = ST_RESP;
        end
      end
      default: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign htrans_o    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hburst_o    = HBURST_SINGLE;
  assign haddr_o     = addr_q;
  assign hwrite_o    = write_q;
  assign hsize_o     = {1'b0, size_q};
  assign hwdata_o    = wdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a timeline model of each transfer is
// compared against the DUT every cycle, plus literal expectations per vector.
module tb_ahb_lite_master;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] haddr_o, hwdata_o, hrdata_i;
  logic        hwrite_o, hready_i, hresp_i;
  logic [2:0]  hsize_o, hburst_o;
  logic [1:0]  htrans_o;

  always #5 hclk = ~hclk;

  ahb_lite_master dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_size_i  (req_size_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .haddr_o     (haddr_o),
    .hwrite_o    (hwrite_o),
    .hsize_o     (hsize_o),
    .hburst_o    (hburst_o),
    .htrans_o    (htrans_o),
    .hwdata_o    (hwdata_o),
    .hready_i    (hready_i),
    .hresp_i     (hresp_i),
    .hrdata_i    (hrdata_i)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int first_valid_cyc = -1000;
  logic prev_valid = 1'b0;

  // Expected bus phase of the current cycle: -1 unchecked, 0 idle, 1 address, 2 data, 3 response.
  int          exp_phase = -1;
  logic        exp_write = 1'b0;
  logic [1:0]  exp_size = 2'b0;
  logic [31:0] exp_addr = 32'b0, exp_hwdata = 32'b0, exp_rdata = 32'b0;
  logic        exp_err = 1'b0;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] repl(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    if (sz == 2'd0) return (d >> (8 * (a % 4))) & 32'hFF;
    if (sz == 2'd1) return (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    return d;
  endfunction

  always @(negedge hclk) begin
    if (exp_phase >= 0) begin
      chk("hburst", {29'b0, hburst_o}, 32'd0);
      chk("htrans", {30'b0, htrans_o}, (exp_phase == 1) ? 32'd2 : 32'd0);
      chk("req_ready", {31'b0, req_ready_o}, {31'b0, exp_phase == 0});
      chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, exp_phase == 3});
      if (exp_phase == 1) begin
        chk("haddr", haddr_o, exp_addr);
        chk("hwrite", {31'b0, hwrite_o}, {31'b0, exp_write});
        chk("hsize", {29'b0, hsize_o}, {30'b0, exp_size});
      end
      if (exp_phase == 2 && exp_write) chk("hwdata", hwdata_o, exp_hwdata);
      if (exp_phase == 3) begin
        chk("rsp_rdata", rsp_rdata_o, exp_rdata);
        chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
      end
    end
    if (rsp_valid_o && !prev_valid) first_valid_cyc = cyc;
    prev_valid = rsp_valid_o;
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] wdata, input int aw, input int dw, input logic err,
                         input logic [31:0] bus_rdata, input int hold, input logic [31:0] lit_rdata,
                         input logic [31:0] lit_hwdata, input int lit_lat);
    logic mis;
    int   acc;
    mis = is_misaligned(sz, addr);
    first_valid_cyc = -1000;
    exp_phase = 0;
    req_valid_i = 1'b1; req_write_i = wr; req_size_i = sz; req_addr_i = addr; req_wdata_i = wdata;
    acc = cyc;
    step();
    // Keep offering a different request while busy; it must not be taken.
    req_addr_i = ~addr; req_write_i = ~wr; req_wdata_i = 32'h5A5A_0F0F; req_size_i = 2'd2;
    exp_write = wr; exp_size = sz; exp_addr = addr; exp_hwdata = repl(sz, wdata);
    if (!mis) begin
      exp_phase = 1;
      for (int i = 0; i <= aw; i++) begin
        hready_i = (i == aw); hresp_i = 1'b0;
        step();
      end
      exp_phase = 2;
      for (int j = 0; j <= dw; j++) begin
        hready_i = (j == dw); hresp_i = err;
        hrdata_i = (j == dw) ? bus_rdata : $urandom;
        if (j == 0 && wr) begin
          @(negedge hclk);
          chk("lit_hwdata", hwdata_o, lit_hwdata);
        end
        step();
      end
      hready_i = 1'b1; hresp_i = 1'b0;
    end
    exp_phase = 3;
    exp_err = mis || err;
    exp_rdata = (mis || err || wr) ? 32'd0 : extract(sz, addr, bus_rdata);
    rsp_ready_i = 1'b0;
    @(negedge hclk);
    chk("lit_rdata", rsp_rdata_o, lit_rdata);
    for (int k = 0; k < hold; k++) step();
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0; req_valid_i = 1'b0;
    exp_phase = 0;
    chk("latency", first_valid_cyc - acc, lit_lat);
    $display("txn wr=%0d size=%0d addr=%h wdata=%h waits=%0d/%0d err=%0d -> rdata=%h err=%0d latency=%0d",
             wr, sz, addr, wdata, aw, dw, err, exp_rdata, exp_err, first_valid_cyc - acc);
    step();
  endtask

  initial begin
    hreset = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'd0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
    rsp_ready_i = 1'b0; hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = 32'd0;
    repeat (3) step();
    hreset = 1'b0;
    exp_phase = 0;
    @(negedge hclk);
    chk("reset_haddr", haddr_o, 32'd0);
    chk("reset_hwrite", {31'b0, hwrite_o}, 32'd0);
    chk("reset_hsize", {29'b0, hsize_o}, 32'd0);
    chk("reset_hwdata", hwdata_o, 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    chk("reset_err", {31'b0, rsp_err_o}, 32'd0);
    step();

    //      wr    sz    addr           wdata          aw dw err  bus_rdata      hold lit_rdata      lit_hwdata     lat
    run_txn(1'b1, 2'd2, 32'h1000_0000, 32'hDEAD_BEEF, 0, 0, 1'b0, 32'h0,         0,   32'h0,         32'hDEAD_BEEF, 3);
    run_txn(1'b0, 2'd0, 32'h1000_0003, 32'h0,         0, 2, 1'b0, 32'hA1B2_C3D4, 1,   32'h0000_00A1, 32'h0,         5);
    run_txn(1'b1, 2'd1, 32'h1000_0002, 32'h0000_1234, 1, 0, 1'b0, 32'h0,         0,   32'h0,         32'h1234_1234, 4);
    run_txn(1'b0, 2'd2, 32'h4000_0000, 32'h0,         0, 1, 1'b1, 32'hFFFF_FFFF, 0,   32'h0,         32'h0,         4);
    run_txn(1'b1, 2'd0, 32'h4000_0001, 32'hFFFF_FF7E, 0, 0, 1'b0, 32'h0,         0,   32'h0,         32'h7E7E_7E7E, 3);
    run_txn(1'b0, 2'd1, 32'h1000_0002, 32'h0,         0, 0, 1'b0, 32'hCAFE_BABE, 0,   32'h0000_CAFE, 32'h0,         3);
    run_txn(1'b0, 2'd0, 32'h1000_0001, 32'h0,         2, 0, 1'b0, 32'h1122_3344, 0,   32'h0000_0033, 32'h0,         5);
    run_txn(1'b0, 2'd2, 32'h1000_0002, 32'h0,         0, 0, 1'b0, 32'h0,         2,   32'h0,         32'h0,         1);
    run_txn(1'b1, 2'd3, 32'h1000_0000, 32'h1111_2222, 0, 0, 1'b0, 32'h0,         0,   32'h0,         32'h0,         1);
    run_txn(1'b0, 2'd1, 32'h1000_0001, 32'h0,         0, 0, 1'b0, 32'h0,         0,   32'h0,         32'h0,         1);
    run_txn(1'b1, 2'd2, 32'h2000_0010, 32'h0BAD_F00D, 1, 1, 1'b1, 32'h0,         5,   32'h0,         32'h0BAD_F00D, 5);

    // Reset during a stalled data phase drops the transfer.
    exp_phase = 0;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h2000_0000;
    exp_write = 1'b0; exp_size = 2'd2; exp_addr = 32'h2000_0000;
    step();
    req_valid_i = 1'b0;
    exp_phase = 1; hready_i = 1'b1;
    step();
    exp_phase = 2; hready_i = 1'b0; hresp_i = 1'b0;
    step();
    hreset = 1'b1;
    step();
    hreset = 1'b0; hready_i = 1'b1;
    exp_phase = 0;
    @(negedge hclk);
    chk("rst_mid_haddr", haddr_o, 32'd0);
    chk("rst_mid_rdata", rsp_rdata_o, 32'd0);
    $display("txn reset during data phase -> idle");
    step();
    run_txn(1'b0, 2'd2, 32'h3000_0004, 32'h0, 0, 0, 1'b0, 32'h8765_4321, 0, 32'h8765_4321, 32'h0, 3);

    exp_phase = -1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
